// File: rtl/inv_player.sv
// Iterative inverse PRESENT bit permutation: resolves BITS_PER_CYCLE output bits per clock.
// Optional forward-permutation self-check is enabled with macro INV_PLAYER_SELFCHECK_EN.
module inv_player #(
    parameter int WIDTH          = 64,
    parameter int BITS_PER_CYCLE = 16
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_permuted,
    output logic [WIDTH-1:0] o_original,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_mismatch
);

    localparam int NCH = WIDTH / BITS_PER_CYCLE;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int IW  = $clog2(WIDTH) + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_capture;
    logic [WIDTH-1:0] r_original;
    logic [WIDTH-1:0] w_inv;
    logic [WIDTH-1:0] w_orig_next;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    w_base;
    logic             w_accept;
    logic             w_last;

    genvar gi;

    // Output bit j comes from captured bit j*(WIDTH/4) mod (WIDTH-1); the top bit is fixed.
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_inv
            localparam logic [IW-1:0] SRC =
                IW'((gi == WIDTH - 1) ? gi : (gi * (WIDTH / 4)) % (WIDTH - 1));
            assign w_inv[gi] = r_capture[SRC];
        end
    endgenerate

    assign w_base = IW'(r_cnt) * IW'(BITS_PER_CYCLE);
    assign w_last = (r_cnt == CW'(NCH - 1));

    always_comb begin
        w_orig_next = r_original;
        w_orig_next[w_base +: BITS_PER_CYCLE] = w_inv[w_base +: BITS_PER_CYCLE];
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_capture  <= '0;
            r_original <= '0;
            r_cnt      <= '0;
        end else if (w_accept) begin
            r_capture <= i_permuted;
            r_cnt     <= '0;
        end else if (r_state == RUN) begin
            r_original <= w_orig_next;
            r_cnt      <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_original = r_original;
    assign o_busy     = (r_state == RUN);
    assign o_done     = (r_state == DONE);

`ifdef INV_PLAYER_SELFCHECK_EN
    logic [WIDTH-1:0] w_fwd;
    logic             r_mismatch;

    // Re-apply the forward permutation to the completed result and compare with the input.
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_fwd
            localparam logic [IW-1:0] DST =
                IW'((gi == WIDTH - 1) ? gi : (gi * (WIDTH / 4)) % (WIDTH - 1));
            assign w_fwd[DST] = w_orig_next[gi];
        end
    endgenerate

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_mismatch <= 1'b0;
        end else if (w_accept) begin
            r_mismatch <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            r_mismatch <= (w_fwd != r_capture);
        end
    end

    assign o_mismatch = r_mismatch;
`else
    assign o_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_inv_player.sv
// Self-checking bench for inv_player: directed and random blocks against a table-driven model.
module tb_inv_player;

    logic        Clock;
    logic        Reset_n;
    logic        i_start;
    logic [63:0] i_permuted;
    logic [63:0] o_original;
    logic        o_busy;
    logic        o_done;
    logic        o_mismatch;

    int total;
    int bad;

    inv_player #(.WIDTH(64), .BITS_PER_CYCLE(16)) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .i_start    (i_start),
        .i_permuted (i_permuted),
        .o_original (o_original),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_mismatch (o_mismatch)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Forward P sends input bit i to position P(i); invert by scattering each permuted bit back.
    function automatic int fwd_pos(input int i);
        if (i == 63) return 63;
        return (i * 16) % 63;
    endfunction

    function automatic logic [63:0] ref_inv(input logic [63:0] p);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 64; k++)
            for (int i = 0; i < 64; i++)
                if (fwd_pos(i) == k) r[i] = p[k];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Runs one block from IDLE/DONE; optionally pulses start with another value mid-RUN.
    task automatic run_block(input logic [63:0] p, input bit pulse, input logic [63:0] p2);
        int n;
        logic [63:0] exp;
        exp = ref_inv(p);
        i_start    = 1'b1;
        i_permuted = p;
        tick();
        i_start    = 1'b0;
        i_permuted = {$urandom, $urandom};
        chk("busy_after_start", 64'(o_busy), 64'd1);
        chk("done_after_start", 64'(o_done), 64'd0);
        n = 0;
        while (!o_done && n < 20) begin
            tick();
            n++;
            if (n == 2 && pulse) begin
                i_start    = 1'b1;
                i_permuted = p2;
            end else begin
                i_start = 1'b0;
            end
        end
        i_start = 1'b0;
        chk("done_latency", 64'(n), 64'd4);
        chk("original", o_original, exp);
        chk("busy_when_done", 64'(o_busy), 64'd0);
        chk("mismatch", 64'(o_mismatch), 64'd0);
        $display("block permuted=%h original=%h cycles=%0d", p, o_original, n);
    endtask

    logic [63:0] vecs [3];

    initial begin
        total      = 0;
        bad        = 0;
        Reset_n    = 1'b0;
        i_start    = 1'b0;
        i_permuted = '0;
        tick();
        tick();
        chk("reset_original", o_original, 64'd0);
        chk("reset_busy", 64'(o_busy), 64'd0);
        chk("reset_done", 64'(o_done), 64'd0);
        chk("reset_mismatch", 64'(o_mismatch), 64'd0);
        Reset_n = 1'b1;
        tick();
        chk("idle_busy", 64'(o_busy), 64'd0);

        // Directed vectors, including the wrap and the fixed top bit.
        chk("v1_expect", ref_inv(64'h0000000000010000), 64'h0000000000000002);
        run_block(64'h0000000000010000, 1'b0, '0);
        run_block(64'h0000000100000000, 1'b0, '0);
        chk("v2_expect", o_original, 64'h0000000000000004);
        run_block(64'h0000000000000002, 1'b0, '0);
        chk("v3_expect", o_original, 64'h0000000000000010);
        run_block(64'h8000000000000000, 1'b0, '0);
        chk("v4_expect", o_original, 64'h8000000000000000);
        run_block(64'hFFFFFFFFFFFFFFFF, 1'b0, '0);
        chk("v5_expect", o_original, 64'hFFFFFFFFFFFFFFFF);
        run_block(64'h0, 1'b0, '0);
        chk("v6_expect", o_original, 64'h0);

        // start pulsed during RUN must be ignored.
        run_block(64'h0123456789ABCDEF, 1'b1, 64'hFEDCBA9876543210);
        tick();
        chk("hold_done", 64'(o_done), 64'd1);
        chk("hold_original", o_original, ref_inv(64'h0123456789ABCDEF));

        for (int r = 0; r < 6; r++) begin
            logic [63:0] v;
            v = {$urandom, $urandom};
            run_block(v, r[0], {$urandom, $urandom});
        end

        // Back-to-back blocks with start held high.
        for (int k = 0; k < 3; k++) vecs[k] = {$urandom, $urandom};
        i_start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_permuted = vecs[k];
            tick();
            chk("b2b_busy", 64'(o_busy), 64'd1);
            chk("b2b_done_drop", 64'(o_done), 64'd0);
            i_permuted = (k < 2) ? vecs[k + 1] : 64'h0;
            tick();
            tick();
            tick();
            chk("b2b_not_yet", 64'(o_done), 64'd0);
            tick();
            chk("b2b_done", 64'(o_done), 64'd1);
            chk("b2b_original", o_original, ref_inv(vecs[k]));
            chk("b2b_mismatch", 64'(o_mismatch), 64'd0);
            $display("b2b block=%0d permuted=%h original=%h", k, vecs[k], o_original);
        end
        i_start = 1'b0;
        tick();

        // Asynchronous reset two cycles into RUN.
        i_start    = 1'b1;
        i_permuted = 64'hFFFFFFFFFFFFFFFF;
        tick();
        i_start = 1'b0;
        tick();
        tick();
        chk("pre_reset_busy", 64'(o_busy), 64'd1);
        Reset_n = 1'b0;
        #1;
        chk("async_original", o_original, 64'd0);
        chk("async_busy", 64'(o_busy), 64'd0);
        chk("async_done", 64'(o_done), 64'd0);
        chk("async_mismatch", 64'(o_mismatch), 64'd0);
        $display("mid-run reset original=%h busy=%0d done=%0d", o_original, o_busy, o_done);
        tick();
        Reset_n = 1'b1;
        tick();
        chk("post_reset_idle", 64'(o_busy | o_done), 64'd0);
        run_block(64'h0000000000010000, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
